// File: rtl/bist_sequencer_if.sv
// Stimulus/response bus between the BIST sequencer (master) and the device under test (slave).
// Channel c of either data bus occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
interface bist_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2
);
  localparam int unsigned BW = NUM_CH * DATA_WIDTH;

  logic          drv_valid;
  logic [BW-1:0] drv_data;
  logic          dut_ready;
  logic          dut_valid;
  logic [BW-1:0] dut_data;

  modport master (
    output drv_valid, drv_data,
    input  dut_ready, dut_valid, dut_data
  );

  modport slave (
    input  drv_valid, drv_data,
    output dut_ready, dut_valid, dut_data
  );
endinterface

// File: rtl/bist_sequencer.sv
// Counted BIST run: drives NUM_CH stimulus channels, compacts DUT responses into per-channel
// MISR signatures, waits out stragglers with a drain timeout and grades against golden values.
module bist_sequencer #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           NUM_CH        = 2,
  parameter int unsigned           CNT_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] POLY          = DATA_WIDTH'(32'h0040_0007),
  parameter int unsigned           DRAIN_TIMEOUT = 256
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [1:0]                   mode_i,
  input  logic [CNT_WIDTH-1:0]         num_patterns_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] seed_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] golden_i,
  input  logic                         ext_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ext_data_i,
  bist_sequencer_if.master             dut_if,
  output logic [NUM_CH*DATA_WIDTH-1:0] sig_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [NUM_CH-1:0]            ch_fail_o
);

  localparam int unsigned BW = NUM_CH * DATA_WIDTH;
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [1:0]  MODE_LFSR = 2'b00;
  localparam logic [1:0]  MODE_EXT  = 2'b01;
  localparam logic [1:0]  MODE_WALK = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CHECK, S_DONE} state_e;

  state_e               state_q;
  logic [1:0]           mode_q;
  logic [CNT_WIDTH-1:0] num_q, issue_q, resp_q;
  logic [BW-1:0]        golden_q, pat_q, sig_q;
  logic [TW-1:0]        timer_q;
  logic [NUM_CH-1:0]    ch_fail_q;
  logic                 drv_valid_q, busy_q, done_q, pass_q;
  logic                 timeout_q, overrun_q, start_lo_q;

  logic                 ext_mode, drv_valid, hs, last_hs, rx, resp_acc, resp_over, resp_full;
  logic                 start_edge;
  logic [1:0]           mode_start;
  logic [BW-1:0]        pat_next, first_pat, misr_next;
  logic [NUM_CH-1:0]    fail;

  function automatic logic [DATA_WIDTH-1:0] galois_step(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], 1'b0} ^ (v[DATA_WIDTH-1] ? POLY : '0);
  endfunction

  // start_lo_q resets to 0 so a start_i held high through reset is not taken as an edge
  assign start_edge = start_i & start_lo_q;
  assign mode_start = (mode_i == 2'b11) ? MODE_LFSR : mode_i;
  assign ext_mode   = (mode_q == MODE_EXT);
  assign drv_valid  = ext_mode ? ((state_q == S_RUN) & ext_valid_i) : drv_valid_q;
  assign hs         = (state_q == S_RUN) & drv_valid & dut_if.dut_ready;
  assign last_hs    = hs & ((issue_q + CNT_WIDTH'(1)) == num_q);
  assign rx         = ((state_q == S_RUN) | (state_q == S_DRAIN)) & dut_if.dut_valid;
  assign resp_acc   = rx & (resp_q != num_q);
  assign resp_over  = rx & (resp_q == num_q);
  assign resp_full  = (resp_q == num_q) | (resp_acc & ((resp_q + CNT_WIDTH'(1)) == num_q));

  // Per-channel generator step, seed correction, MISR update and signature compare
  always_comb begin
    pat_next  = '0;
    first_pat = '0;
    misr_next = '0;
    fail      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pat_next[c*DATA_WIDTH +: DATA_WIDTH] = (mode_q == MODE_WALK)
        ? {pat_q[c*DATA_WIDTH +: DATA_WIDTH-1], pat_q[c*DATA_WIDTH + DATA_WIDTH-1]}
        : galois_step(pat_q[c*DATA_WIDTH +: DATA_WIDTH]);
      if (mode_start == MODE_WALK || seed_i[c*DATA_WIDTH +: DATA_WIDTH] == '0)
        first_pat[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(1);
      else
        first_pat[c*DATA_WIDTH +: DATA_WIDTH] = seed_i[c*DATA_WIDTH +: DATA_WIDTH];
      misr_next[c*DATA_WIDTH +: DATA_WIDTH] = galois_step(sig_q[c*DATA_WIDTH +: DATA_WIDTH])
                                              ^ dut_if.dut_data[c*DATA_WIDTH +: DATA_WIDTH];
      fail[c] = (sig_q[c*DATA_WIDTH +: DATA_WIDTH] != golden_q[c*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      num_q       <= '0;
      issue_q     <= '0;
      resp_q      <= '0;
      golden_q    <= '0;
      pat_q       <= '0;
      sig_q       <= '0;
      timer_q     <= '0;
      ch_fail_q   <= '0;
      drv_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      start_lo_q  <= 1'b0;
    end else begin
      start_lo_q <= ~start_i;
      if (abort_i && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        drv_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        ch_fail_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (start_edge && !abort_i) begin
              mode_q      <= mode_start;
              num_q       <= num_patterns_i;
              golden_q    <= golden_i;
              issue_q     <= '0;
              resp_q      <= '0;
              sig_q       <= '0;
              timeout_q   <= 1'b0;
              overrun_q   <= 1'b0;
              pat_q       <= first_pat;
              done_q      <= 1'b0;
              pass_q      <= 1'b0;
              ch_fail_q   <= '0;
              busy_q      <= 1'b1;
              drv_valid_q <= (num_patterns_i != '0) && (mode_start != MODE_EXT);
              state_q     <= (num_patterns_i == '0) ? S_CHECK : S_RUN;
            end
          end
          S_RUN: begin
            if (hs) begin
              issue_q <= issue_q + CNT_WIDTH'(1);
              pat_q   <= pat_next;
            end
            if (last_hs) begin
              drv_valid_q <= 1'b0;
              timer_q     <= '0;
              state_q     <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            timer_q <= timer_q + TW'(1);
            if (resp_full) begin
              state_q <= S_CHECK;
            end else if (timer_q == TW'(DRAIN_TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              state_q   <= S_CHECK;
            end
          end
          S_CHECK: begin
            ch_fail_q <= fail;
            pass_q    <= (fail == '0) && !timeout_q && !overrun_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase

        // Response compaction runs alongside stimulus in RUN and DRAIN
        if (resp_acc) begin
          sig_q  <= misr_next;
          resp_q <= resp_q + CNT_WIDTH'(1);
        end
        if (resp_over) overrun_q <= 1'b1;
      end
    end
  end

  // External mode passes stimulus straight through; otherwise the pattern register drives
  assign dut_if.drv_valid = drv_valid;
  assign dut_if.drv_data  = (ext_mode && state_q == S_RUN) ? ext_data_i : pat_q;
  assign sig_o            = sig_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign ch_fail_o        = ch_fail_q;

endmodule
